// File: rtl/pipe_mem_pkg.sv
// Shared types and constants for the MEM stage: FSM state, funct3 codes,
// the default access timeout, and a funct3 legality helper.
package pipe_mem_pkg;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam int DEFAULT_MAX_WAIT = 16;

  // Unsigned variants only exist for loads; anything else is illegal.
  function automatic logic f3_legal(input logic [2:0] f3, input logic is_store);
    logic ok;
    case (f3)
      F3_B, F3_H, F3_W: ok = 1'b1;
      F3_BU, F3_HU:     ok = ~is_store;
      default:          ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/pipe_mem_stage_align.sv
// Combinational byte-lane logic: store byte enables and replication, the
// bad-op check on the incoming op, and extraction/extension of load data
// using the funct3 and lane captured when the access was issued.
module load_store_align
  import pipe_mem_pkg::*;
(
  input  logic [2:0]  st_funct3_i,
  input  logic        st_is_store_i,
  input  logic [1:0]  st_lane_i,
  input  logic [31:0] st_data_i,
  output logic [3:0]  st_be_o,
  output logic [31:0] st_wdata_o,
  output logic        st_bad_o,
  input  logic [2:0]  ld_funct3_i,
  input  logic [1:0]  ld_lane_i,
  input  logic [31:0] ld_rdata_i,
  output logic [31:0] ld_data_o
);

  logic [3:0]  w_be_raw;
  logic        w_misalign;
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Store lane enables, data replication and alignment check by access size.
  always_comb begin
    w_be_raw   = 4'b0000;
    st_wdata_o = st_data_i;
    w_misalign = 1'b0;
    case (st_funct3_i)
      F3_B, F3_BU: begin
        w_be_raw   = 4'b0001 << st_lane_i;
        st_wdata_o = {4{st_data_i[7:0]}};
      end
      F3_H, F3_HU: begin
        w_be_raw   = 4'b0011 << st_lane_i;
        st_wdata_o = {2{st_data_i[15:0]}};
        w_misalign = st_lane_i[0];
      end
      F3_W: begin
        w_be_raw   = 4'b1111;
        w_misalign = (st_lane_i != 2'b00);
      end
      default: begin
        w_be_raw   = 4'b0000;
        w_misalign = 1'b0;
      end
    endcase
  end

  // Reads never assert byte enables.
  assign st_be_o  = st_is_store_i ? w_be_raw : 4'b0000;
  assign st_bad_o = w_misalign | ~f3_legal(st_funct3_i, st_is_store_i);

  // Pick the addressed byte and halfword out of the returned word.
  always_comb begin
    w_byte = ld_rdata_i[7:0];
    case (ld_lane_i)
      2'b00:   w_byte = ld_rdata_i[7:0];
      2'b01:   w_byte = ld_rdata_i[15:8];
      2'b10:   w_byte = ld_rdata_i[23:16];
      2'b11:   w_byte = ld_rdata_i[31:24];
      default: w_byte = ld_rdata_i[7:0];
    endcase
    if (ld_lane_i[1]) begin
      w_half = ld_rdata_i[31:16];
    end else begin
      w_half = ld_rdata_i[15:0];
    end
  end

  // Sign- or zero-extend the selected field according to the load type.
  always_comb begin
    ld_data_o = ld_rdata_i;
    case (ld_funct3_i)
      F3_B:    ld_data_o = {{24{w_byte[7]}}, w_byte};
      F3_H:    ld_data_o = {{16{w_half[15]}}, w_half};
      F3_BU:   ld_data_o = {24'h000000, w_byte};
      F3_HU:   ld_data_o = {16'h0000, w_half};
      default: ld_data_o = ld_rdata_i;
    endcase
  end

endmodule

// File: rtl/pipe_mem_stage.sv
// MEM stage of the RV32I pipeline: issues loads/stores on a req/ack port,
// stalls upstream while an access is outstanding, aborts hung accesses
// after MAX_WAIT cycles, and owns the MEM/WB pipeline register.
module pipe_mem_stage
  import pipe_mem_pkg::*;
#(
  parameter int MAX_WAIT = DEFAULT_MAX_WAIT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        valid_i,
  input  logic        mem_read_i,
  input  logic        mem_write_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] alu_result_i,
  input  logic [31:0] store_data_i,
  input  logic [4:0]  rd_i,
  input  logic        reg_write_i,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic [31:0] dmem_addr_o,
  output logic [31:0] dmem_wdata_o,
  output logic [3:0]  dmem_be_o,
  input  logic [31:0] dmem_rdata_i,
  input  logic        dmem_ack_i,
  output logic        stall_o,
  output logic        wb_valid_o,
  output logic        wb_reg_write_o,
  output logic [4:0]  wb_rd_o,
  output logic [31:0] wb_data_o,
  output logic        misalign_o,
  output logic        timeout_o
);

  // Abort fires in the MAX_WAIT-th ACCESS cycle, i.e. when the counter
  // (cleared on entry) still reads MAX_WAIT-1.
  localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [7:0]  r_wait;
  logic        r_req;
  logic        r_we;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [3:0]  r_be;
  logic        r_is_load;
  logic [2:0]  r_funct3;
  logic [1:0]  r_lane;
  logic [4:0]  r_rd;
  logic        r_reg_write;
  logic [31:0] r_alu;
  logic        r_wb_valid;
  logic        r_wb_reg_write;
  logic [4:0]  r_wb_rd;
  logic [31:0] r_wb_data;
  logic        r_misalign;
  logic        r_timeout;

  logic        w_mem_op;
  logic        w_bad;
  logic        w_good_op;
  logic        w_bad_op;
  logic        w_timeout_abort;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic [31:0] w_load_data;

  assign w_mem_op        = valid_i & (mem_read_i | mem_write_i);
  assign w_good_op       = w_mem_op & ~w_bad;
  assign w_bad_op        = w_mem_op & w_bad;
  assign w_timeout_abort = (r_state == ST_ACCESS) & ~dmem_ack_i & (r_wait == WAIT_LAST);

  assign stall_o = ((r_state == ST_IDLE) & w_good_op) |
                   ((r_state == ST_ACCESS) & ~dmem_ack_i & ~w_timeout_abort);

  load_store_align u_align (
    .st_funct3_i   (funct3_i),
    .st_is_store_i (mem_write_i),
    .st_lane_i     (alu_result_i[1:0]),
    .st_data_i     (store_data_i),
    .st_be_o       (w_be),
    .st_wdata_o    (w_wdata),
    .st_bad_o      (w_bad),
    .ld_funct3_i   (r_funct3),
    .ld_lane_i     (r_lane),
    .ld_rdata_i    (dmem_rdata_i),
    .ld_data_o     (w_load_data)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state: enter ACCESS on a good op, leave on ack or timeout abort.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_good_op) begin
          w_state_nxt = ST_ACCESS;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_ACCESS: begin
        if (dmem_ack_i || w_timeout_abort) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_ACCESS;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Request port, wait counter, MEM/WB register and error pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wait         <= 8'd0;
      r_req          <= 1'b0;
      r_we           <= 1'b0;
      r_addr         <= 32'h0000_0000;
      r_wdata        <= 32'h0000_0000;
      r_be           <= 4'b0000;
      r_is_load      <= 1'b0;
      r_funct3       <= 3'b000;
      r_lane         <= 2'b00;
      r_rd           <= 5'd0;
      r_reg_write    <= 1'b0;
      r_alu          <= 32'h0000_0000;
      r_wb_valid     <= 1'b0;
      r_wb_reg_write <= 1'b0;
      r_wb_rd        <= 5'd0;
      r_wb_data      <= 32'h0000_0000;
      r_misalign     <= 1'b0;
      r_timeout      <= 1'b0;
    end else begin
      r_misalign <= 1'b0;
      r_timeout  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_good_op) begin
            r_wait      <= 8'd0;
            r_req       <= 1'b1;
            r_we        <= mem_write_i;
            r_addr      <= {alu_result_i[31:2], 2'b00};
            r_wdata     <= w_wdata;
            r_be        <= w_be;
            r_is_load   <= mem_read_i & ~mem_write_i;
            r_funct3    <= funct3_i;
            r_lane      <= alu_result_i[1:0];
            r_rd        <= rd_i;
            r_reg_write <= reg_write_i;
            r_alu       <= alu_result_i;
          end else if (w_bad_op) begin
            r_misalign     <= 1'b1;
            r_wb_valid     <= 1'b0;
            r_wb_reg_write <= 1'b0;
            r_wb_rd        <= 5'd0;
            r_wb_data      <= 32'h0000_0000;
          end else begin
            r_wb_valid     <= valid_i;
            r_wb_reg_write <= reg_write_i;
            r_wb_rd        <= rd_i;
            r_wb_data      <= alu_result_i;
          end
        end
        ST_ACCESS: begin
          if (dmem_ack_i) begin
            r_wait         <= 8'd0;
            r_req          <= 1'b0;
            r_we           <= 1'b0;
            r_be           <= 4'b0000;
            r_wb_valid     <= 1'b1;
            r_wb_reg_write <= r_reg_write;
            r_wb_rd        <= r_rd;
            r_wb_data      <= r_is_load ? w_load_data : r_alu;
          end else if (w_timeout_abort) begin
            r_wait         <= 8'd0;
            r_req          <= 1'b0;
            r_we           <= 1'b0;
            r_be           <= 4'b0000;
            r_timeout      <= 1'b1;
            r_wb_valid     <= 1'b0;
            r_wb_reg_write <= 1'b0;
            r_wb_rd        <= 5'd0;
            r_wb_data      <= 32'h0000_0000;
          end else begin
            r_wait <= r_wait + 8'd1;
          end
        end
        default: begin
          r_req <= 1'b0;
        end
      endcase
    end
  end

  assign dmem_req_o     = r_req;
  assign dmem_we_o      = r_we;
  assign dmem_addr_o    = r_addr;
  assign dmem_wdata_o   = r_wdata;
  assign dmem_be_o      = r_be;
  assign wb_valid_o     = r_wb_valid;
  assign wb_reg_write_o = r_wb_reg_write;
  assign wb_rd_o        = r_wb_rd;
  assign wb_data_o      = r_wb_data;
  assign misalign_o     = r_misalign;
  assign timeout_o      = r_timeout;

endmodule

// File: tb/tb_pipe_mem_stage.sv
// Directed testbench for pipe_mem_stage with MAX_WAIT = 4.
module tb_pipe_mem_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid_i, mem_read_i, mem_write_i, reg_write_i;
  logic [2:0]  funct3_i;
  logic [31:0] alu_result_i, store_data_i, dmem_rdata_i;
  logic [4:0]  rd_i;
  logic        dmem_ack_i;
  logic        dmem_req_o, dmem_we_o, stall_o;
  logic [31:0] dmem_addr_o, dmem_wdata_o, wb_data_o;
  logic [3:0]  dmem_be_o;
  logic        wb_valid_o, wb_reg_write_o, misalign_o, timeout_o;
  logic [4:0]  wb_rd_o;

  int n_checks = 0;
  int n_errors = 0;

  pipe_mem_stage #(.MAX_WAIT(4)) dut (
    .clk(clk), .reset(reset), .valid_i(valid_i), .mem_read_i(mem_read_i),
    .mem_write_i(mem_write_i), .funct3_i(funct3_i), .alu_result_i(alu_result_i),
    .store_data_i(store_data_i), .rd_i(rd_i), .reg_write_i(reg_write_i),
    .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o),
    .dmem_wdata_o(dmem_wdata_o), .dmem_be_o(dmem_be_o), .dmem_rdata_i(dmem_rdata_i),
    .dmem_ack_i(dmem_ack_i), .stall_o(stall_o), .wb_valid_o(wb_valid_o),
    .wb_reg_write_o(wb_reg_write_o), .wb_rd_o(wb_rd_o), .wb_data_o(wb_data_o),
    .misalign_o(misalign_o), .timeout_o(timeout_o)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    valid_i = 1'b0; mem_read_i = 1'b0; mem_write_i = 1'b0; reg_write_i = 1'b0;
    funct3_i = 3'b000; alu_result_i = 32'h0; store_data_i = 32'h0; rd_i = 5'd0;
    dmem_ack_i = 1'b0; dmem_rdata_i = 32'h0;
  endtask

  task automatic set_op(input logic rd_en, input logic wr_en, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] sdata,
                        input logic [4:0] rd, input logic rw);
    valid_i = 1'b1; mem_read_i = rd_en; mem_write_i = wr_en; funct3_i = f3;
    alu_result_i = addr; store_data_i = sdata; rd_i = rd; reg_write_i = rw;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle_inputs();
    step(); step();
    n_checks++; if ({dmem_req_o, dmem_we_o, dmem_be_o, misalign_o, timeout_o} !== 8'h00) begin n_errors++; $display("FAIL reset_ctl: got %h want 00", {dmem_req_o, dmem_we_o, dmem_be_o, misalign_o, timeout_o}); end
    n_checks++; if ({dmem_addr_o, dmem_wdata_o} !== 64'h0) begin n_errors++; $display("FAIL reset_dmem: got %h want 0", {dmem_addr_o, dmem_wdata_o}); end
    n_checks++; if ({wb_valid_o, wb_reg_write_o, wb_rd_o, wb_data_o} !== 39'h0) begin n_errors++; $display("FAIL reset_wb: got %h want 0", {wb_valid_o, wb_reg_write_o, wb_rd_o, wb_data_o}); end
    n_checks++; if (stall_o !== 1'b0) begin n_errors++; $display("FAIL reset_stall: got %b want 0", stall_o); end
    reset = 1'b0;
    step();
  endtask

  task automatic test_alu();
    set_op(1'b0, 1'b0, 3'b000, 32'h0000_1234, 32'h0, 5'd5, 1'b1);
    #1;
    n_checks++; if (stall_o !== 1'b0) begin n_errors++; $display("FAIL alu_stall: got %b want 0", stall_o); end
    step();
    n_checks++; if ({wb_valid_o, wb_reg_write_o, wb_rd_o} !== 7'b1100101) begin n_errors++; $display("FAIL alu_wb_ctl: got %b want 1100101", {wb_valid_o, wb_reg_write_o, wb_rd_o}); end
    n_checks++; if (wb_data_o !== 32'h0000_1234) begin n_errors++; $display("FAIL alu_wb_data: got %h want 00001234", wb_data_o); end
    n_checks++; if (dmem_req_o !== 1'b0) begin n_errors++; $display("FAIL alu_req: got %b want 0", dmem_req_o); end
    idle_inputs();
    step();
  endtask

  task automatic test_lb();
    int stall_cycles = 0;
    set_op(1'b1, 1'b0, 3'b000, 32'h0000_0103, 32'h0, 5'd7, 1'b1);
    #1;
    if (stall_o === 1'b1) stall_cycles++;
    step();
    n_checks++; if ({dmem_req_o, dmem_we_o, dmem_be_o} !== 6'b100000) begin n_errors++; $display("FAIL lb_req: got %b want 100000", {dmem_req_o, dmem_we_o, dmem_be_o}); end
    n_checks++; if (dmem_addr_o !== 32'h0000_0100) begin n_errors++; $display("FAIL lb_addr: got %h want 00000100", dmem_addr_o); end
    dmem_ack_i = 1'b1; dmem_rdata_i = 32'h80FF_FFFF;
    #1;
    if (stall_o === 1'b1) stall_cycles++;
    n_checks++; if (stall_cycles !== 1) begin n_errors++; $display("FAIL lb_stall_cycles: got %0d want 1", stall_cycles); end
    step();
    idle_inputs();
    n_checks++; if (wb_data_o !== 32'hFFFF_FF80) begin n_errors++; $display("FAIL lb_wb_data: got %h want ffffff80", wb_data_o); end
    n_checks++; if ({dmem_req_o, wb_valid_o, wb_reg_write_o, wb_rd_o} !== 8'b01100111) begin n_errors++; $display("FAIL lb_wb_ctl: got %b want 01100111", {dmem_req_o, wb_valid_o, wb_reg_write_o, wb_rd_o}); end
    step();
  endtask

  // Ack arrives in the 4th ACCESS cycle, which with MAX_WAIT=4 coincides with the abort condition.
  task automatic test_sh_wait();
    set_op(1'b0, 1'b1, 3'b001, 32'h0000_0202, 32'h0000_ABCD, 5'd0, 1'b0);
    #1;
    n_checks++; if (stall_o !== 1'b1) begin n_errors++; $display("FAIL sh_stall_idle: got %b want 1", stall_o); end
    step();
    for (int i = 0; i < 4; i++) begin
      n_checks++; if ({dmem_req_o, dmem_we_o, dmem_be_o} !== 6'b111100) begin n_errors++; $display("FAIL sh_req_c%0d: got %b want 111100", i, {dmem_req_o, dmem_we_o, dmem_be_o}); end
      n_checks++; if ({dmem_addr_o, dmem_wdata_o} !== {32'h0000_0200, 32'hABCD_ABCD}) begin n_errors++; $display("FAIL sh_addr_wdata_c%0d: got %h want 00000200abcdabcd", i, {dmem_addr_o, dmem_wdata_o}); end
      if (i == 3) dmem_ack_i = 1'b1;
      #1;
      n_checks++; if (stall_o !== (i < 3)) begin n_errors++; $display("FAIL sh_stall_c%0d: got %b want %b", i, stall_o, (i < 3)); end
      step();
    end
    idle_inputs();
    n_checks++; if ({dmem_req_o, wb_valid_o, wb_reg_write_o, timeout_o} !== 4'b0100) begin n_errors++; $display("FAIL sh_wb_ctl: got %b want 0100", {dmem_req_o, wb_valid_o, wb_reg_write_o, timeout_o}); end
    n_checks++; if (wb_data_o !== 32'h0000_0202) begin n_errors++; $display("FAIL sh_wb_data: got %h want 00000202", wb_data_o); end
    step();
  endtask

  task automatic test_misalign();
    set_op(1'b1, 1'b0, 3'b010, 32'h0000_0006, 32'h0, 5'd4, 1'b1);
    #1;
    n_checks++; if (stall_o !== 1'b0) begin n_errors++; $display("FAIL mis_stall: got %b want 0", stall_o); end
    step();
    idle_inputs();
    n_checks++; if ({misalign_o, dmem_req_o, wb_valid_o, wb_reg_write_o} !== 4'b1000) begin n_errors++; $display("FAIL mis_pulse: got %b want 1000", {misalign_o, dmem_req_o, wb_valid_o, wb_reg_write_o}); end
    step();
    n_checks++; if (misalign_o !== 1'b0) begin n_errors++; $display("FAIL mis_pulse_end: got %b want 0", misalign_o); end
  endtask

  task automatic test_timeout();
    set_op(1'b1, 1'b0, 3'b010, 32'h0000_0040, 32'h0, 5'd6, 1'b1);
    step();
    for (int i = 0; i < 4; i++) begin
      n_checks++; if ({dmem_req_o, dmem_addr_o} !== {1'b1, 32'h0000_0040}) begin n_errors++; $display("FAIL to_req_c%0d: got %h want 100000040", i, {dmem_req_o, dmem_addr_o}); end
      #1;
      n_checks++; if (stall_o !== (i < 3)) begin n_errors++; $display("FAIL to_stall_c%0d: got %b want %b", i, stall_o, (i < 3)); end
      step();
    end
    idle_inputs();
    n_checks++; if ({dmem_req_o, timeout_o, wb_valid_o, wb_reg_write_o} !== 4'b0100) begin n_errors++; $display("FAIL to_abort: got %b want 0100", {dmem_req_o, timeout_o, wb_valid_o, wb_reg_write_o}); end
    step();
    n_checks++; if (timeout_o !== 1'b0) begin n_errors++; $display("FAIL to_pulse_end: got %b want 0", timeout_o); end
  endtask

  task automatic test_reset_access();
    set_op(1'b1, 1'b0, 3'b010, 32'h0000_0080, 32'h0, 5'd8, 1'b1);
    step();
    step();
    n_checks++; if (dmem_req_o !== 1'b1) begin n_errors++; $display("FAIL rst_acc_req: got %b want 1", dmem_req_o); end
    reset = 1'b1;
    step();
    reset = 1'b0;
    idle_inputs();
    n_checks++; if ({dmem_req_o, dmem_we_o, dmem_be_o, wb_valid_o, misalign_o, timeout_o} !== 9'h0) begin n_errors++; $display("FAIL rst_acc_out: got %b want 0", {dmem_req_o, dmem_we_o, dmem_be_o, wb_valid_o, misalign_o, timeout_o}); end
    n_checks++; if (dmem_addr_o !== 32'h0) begin n_errors++; $display("FAIL rst_acc_addr: got %h want 0", dmem_addr_o); end
    dmem_ack_i = 1'b1; dmem_rdata_i = 32'hDEAD_BEEF;
    #1;
    n_checks++; if (stall_o !== 1'b0) begin n_errors++; $display("FAIL rst_late_ack_stall: got %b want 0", stall_o); end
    step();
    dmem_ack_i = 1'b0;
    n_checks++; if ({dmem_req_o, wb_valid_o, wb_data_o} !== 34'h0) begin n_errors++; $display("FAIL rst_late_ack_wb: got %h want 0", {dmem_req_o, wb_valid_o, wb_data_o}); end
    // A fresh load must still take exactly the IDLE stall cycle, proving the FSM is in IDLE.
    set_op(1'b1, 1'b0, 3'b010, 32'h0000_0010, 32'h0, 5'd2, 1'b1);
    #1;
    n_checks++; if (stall_o !== 1'b1) begin n_errors++; $display("FAIL rst_idle_stall: got %b want 1", stall_o); end
    step();
    dmem_ack_i = 1'b1; dmem_rdata_i = 32'h0BAD_F00D;
    step();
    idle_inputs();
    n_checks++; if ({wb_valid_o, wb_data_o} !== {1'b1, 32'h0BAD_F00D}) begin n_errors++; $display("FAIL rst_idle_lw: got %h want 10badf00d", {wb_valid_o, wb_data_o}); end
    step();
  endtask

  task automatic test_back_to_back();
    set_op(1'b1, 1'b0, 3'b100, 32'h0000_0101, 32'h0, 5'd3, 1'b1);
    step();
    n_checks++; if ({dmem_addr_o, dmem_be_o} !== {32'h0000_0100, 4'b0000}) begin n_errors++; $display("FAIL b2b_lbu_req: got %h want 000001000", {dmem_addr_o, dmem_be_o}); end
    dmem_ack_i = 1'b1; dmem_rdata_i = 32'h1234_5678;
    step();
    n_checks++; if (wb_data_o !== 32'h0000_0056) begin n_errors++; $display("FAIL b2b_lbu_data: got %h want 00000056", wb_data_o); end
    dmem_ack_i = 1'b0;
    set_op(1'b0, 1'b1, 3'b000, 32'h0000_0001, 32'h0000_00AB, 5'd0, 1'b0);
    #1;
    n_checks++; if (stall_o !== 1'b1) begin n_errors++; $display("FAIL b2b_sb_stall: got %b want 1", stall_o); end
    step();
    n_checks++; if ({dmem_we_o, dmem_be_o, dmem_addr_o, dmem_wdata_o} !== {1'b1, 4'b0010, 32'h0, 32'hABAB_ABAB}) begin n_errors++; $display("FAIL b2b_sb_req: got %h want 1200000000abababab", {dmem_we_o, dmem_be_o, dmem_addr_o, dmem_wdata_o}); end
    dmem_ack_i = 1'b1;
    step();
    n_checks++; if ({wb_valid_o, wb_reg_write_o, wb_data_o} !== {2'b10, 32'h0000_0001}) begin n_errors++; $display("FAIL b2b_sb_wb: got %h want 200000001", {wb_valid_o, wb_reg_write_o, wb_data_o}); end
    dmem_ack_i = 1'b0;
    set_op(1'b1, 1'b0, 3'b001, 32'h0000_0102, 32'h0, 5'd9, 1'b1);
    step();
    n_checks++; if ({dmem_req_o, dmem_addr_o} !== {1'b1, 32'h0000_0100}) begin n_errors++; $display("FAIL b2b_lh_req: got %h want 100000100", {dmem_req_o, dmem_addr_o}); end
    dmem_ack_i = 1'b1; dmem_rdata_i = 32'h9ABC_0000;
    step();
    idle_inputs();
    n_checks++; if ({wb_rd_o, wb_data_o} !== {5'd9, 32'hFFFF_9ABC}) begin n_errors++; $display("FAIL b2b_lh_data: got %h want 9ffff9abc", {wb_rd_o, wb_data_o}); end
    step();
  endtask

  initial begin
    test_reset();
    test_alu();
    test_lb();
    test_sh_wait();
    test_misalign();
    test_timeout();
    test_reset_access();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
